// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA-3 stream arbiter.
// Mode encodings carried on TUSER toward the mode/output stage.
package sha_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        STREAM      = 2'd1,
        WAIT_DIGEST = 2'd2
    } arb_state_t;

    localparam int SHA_USER_W = 4;

    localparam logic [SHA_USER_W-1:0] MODE_SHA3_224 = 4'h0;
    localparam logic [SHA_USER_W-1:0] MODE_SHA3_256 = 4'h1;
    localparam logic [SHA_USER_W-1:0] MODE_SHA3_384 = 4'h2;
    localparam logic [SHA_USER_W-1:0] MODE_SHA3_512 = 4'h3;
    localparam logic [SHA_USER_W-1:0] MODE_SHAKE128 = 4'h4;
    localparam logic [SHA_USER_W-1:0] MODE_SHAKE256 = 4'h5;

endpackage

// File: rtl/sha_rr_pick.sv
// Combinational requester picker for the SHA stream arbiter.
// Round-robin from last_grant+1; SHA_ARB_FIXED_PRIO_EN selects lowest index.
module sha_rr_pick
    import sha_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [N_REQ-1:0]    req_i,
    input  logic [ID_WIDTH-1:0] last_grant_i,
    output logic [ID_WIDTH-1:0] winner_o,
    output logic                any_req_o
);

    assign any_req_o = |req_i;

`ifdef SHA_ARB_FIXED_PRIO_EN

    logic unused_last;
    assign unused_last = ^last_grant_i;

    // Lowest set index wins; scanning downward leaves the lowest hit last.
    always_comb begin
        winner_o = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if ((req_i & (N_REQ'(1) << i)) != '0) begin
                winner_o = ID_WIDTH'(i);
            end
        end
    end

`else

    int   idx;
    logic found;

    // First requester found scanning upward from last_grant+1, wrapping.
    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_grant_i) + i) % N_REQ;
            if (!found && ((req_i & (N_REQ'(1) << idx)) != '0)) begin
                winner_o = ID_WIDTH'(idx);
                found    = 1'b1;
            end
        end
    end

`endif

endmodule

// File: rtl/sha_stream_arbiter.sv
// Message-locked arbiter sharing one SHA-3 pipeline among N_REQ streams.
// Optional SHA_ARB_FIXED_PRIO_EN switches the picker to fixed priority.
module sha_stream_arbiter
    import sha_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int N_REQ      = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic [N_REQ-1:0]             s_TVALID,
    output logic [N_REQ-1:0]             s_TREADY,
    input  logic [N_REQ*DATA_WIDTH-1:0]  s_TDATA,
    input  logic [N_REQ-1:0]             s_TLAST,
    input  logic [N_REQ*SHA_USER_W-1:0]  s_TUSER,
    output logic                         m_TVALID,
    input  logic                         m_TREADY,
    output logic [DATA_WIDTH-1:0]        m_TDATA,
    output logic                         m_TLAST,
    output logic [SHA_USER_W-1:0]        m_TUSER,
    output logic [ID_WIDTH-1:0]          m_TID,
    input  logic                         digest_done,
    output logic                         busy,
    output logic [ID_WIDTH-1:0]          grant_id
);

    arb_state_t              state_q, state_d;
    logic [ID_WIDTH-1:0]     grant_q, grant_d;
    logic [ID_WIDTH-1:0]     last_q, last_d;

    logic                    mvalid_q, mvalid_d;
    logic [DATA_WIDTH-1:0]   mdata_q, mdata_d;
    logic                    mlast_q, mlast_d;
    logic [SHA_USER_W-1:0]   muser_q, muser_d;
    logic [ID_WIDTH-1:0]     mtid_q, mtid_d;

    logic [ID_WIDTH-1:0]     winner;
    logic                    any_req;

    logic [N_REQ-1:0]        gnt_mask;
    logic                    gnt_valid;
    logic                    sel_last;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [SHA_USER_W-1:0]   sel_user;
    logic                    slot_free;
    logic                    accept;

    sha_rr_pick #(
        .N_REQ    (N_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req_i        (s_TVALID),
        .last_grant_i (last_q),
        .winner_o     (winner),
        .any_req_o    (any_req)
    );

    // Route the granted requester's beat fields onto the slice inputs.
    always_comb begin
        gnt_mask  = N_REQ'(1) << grant_q;
        gnt_valid = (s_TVALID & gnt_mask) != '0;
        sel_last  = (s_TLAST & gnt_mask) != '0;
        sel_data  = DATA_WIDTH'(s_TDATA >> (int'(grant_q) * DATA_WIDTH));
        sel_user  = SHA_USER_W'(s_TUSER >> (int'(grant_q) * SHA_USER_W));
    end

    // Ready depends only on state and slice occupancy, never on s_TVALID.
    always_comb begin
        slot_free = !mvalid_q || m_TREADY;
        s_TREADY  = '0;
        if (state_q == STREAM && slot_free) begin
            s_TREADY = gnt_mask;
        end
        accept = (state_q == STREAM) && slot_free && gnt_valid;
    end

    // Grant FSM: pick in IDLE, hold through TLAST, release on digest_done.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    last_d  = winner;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (accept && sel_last) begin
                    state_d = WAIT_DIGEST;
                end
            end
            WAIT_DIGEST: begin
                if (digest_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output slice: load on accept, otherwise drain on m_TREADY.
    always_comb begin
        mvalid_d = mvalid_q;
        mdata_d  = mdata_q;
        mlast_d  = mlast_q;
        muser_d  = muser_q;
        mtid_d   = mtid_q;
        if (accept) begin
            mvalid_d = 1'b1;
            mdata_d  = sel_data;
            mlast_d  = sel_last;
            muser_d  = sel_user;
            mtid_d   = grant_q;
        end else if (m_TREADY) begin
            mvalid_d = 1'b0;
        end
    end

    // State and grant registers; last_grant resets so requester 0 wins first.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= ID_WIDTH'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Slice registers; reset drops any in-flight beat.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            mvalid_q <= 1'b0;
            mdata_q  <= '0;
            mlast_q  <= 1'b0;
            muser_q  <= '0;
            mtid_q   <= '0;
        end else begin
            mvalid_q <= mvalid_d;
            mdata_q  <= mdata_d;
            mlast_q  <= mlast_d;
            muser_q  <= muser_d;
            mtid_q   <= mtid_d;
        end
    end

    assign m_TVALID = mvalid_q;
    assign m_TDATA  = mdata_q;
    assign m_TLAST  = mlast_q;
    assign m_TUSER  = muser_q;
    assign m_TID    = mtid_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_sha_stream_arbiter.sv
// Scoreboard bench for sha_stream_arbiter.
// Honours SHA_ARB_FIXED_PRIO_EN in its reference model.
module tb_sha_stream_arbiter;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int IW    = 2;
    localparam int DWALL = N * DW;
    localparam int UWALL = N * 4;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic [3:0]  user;
        logic [1:0]  tid;
    } beat_t;

    logic             ACLK = 1'b0;
    logic             ARESETn;
    logic [N-1:0]     s_TVALID;
    logic [N-1:0]     s_TREADY;
    logic [DWALL-1:0] s_TDATA;
    logic [N-1:0]     s_TLAST;
    logic [UWALL-1:0] s_TUSER;
    logic             m_TVALID;
    logic             m_TREADY;
    logic [DW-1:0]    m_TDATA;
    logic             m_TLAST;
    logic [3:0]       m_TUSER;
    logic [IW-1:0]    m_TID;
    logic             digest_done;
    logic             busy;
    logic [IW-1:0]    grant_id;

    int    errors = 0;
    int    checks = 0;
    beat_t rq [N][64];
    int    head [N];
    int    tail [N];
    beat_t exp_q [$];
    int    lg_model = N - 1;
    int    cd = 0;
    bit    dd_check = 0;
    int    tog = 0;

    always #5 ACLK = ~ACLK;

    sha_stream_arbiter #(
        .DATA_WIDTH (DW),
        .N_REQ      (N),
        .ID_WIDTH   (IW)
    ) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .s_TVALID    (s_TVALID),
        .s_TREADY    (s_TREADY),
        .s_TDATA     (s_TDATA),
        .s_TLAST     (s_TLAST),
        .s_TUSER     (s_TUSER),
        .m_TVALID    (m_TVALID),
        .m_TREADY    (m_TREADY),
        .m_TDATA     (m_TDATA),
        .m_TLAST     (m_TLAST),
        .m_TUSER     (m_TUSER),
        .m_TID       (m_TID),
        .digest_done (digest_done),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every output handshake pops one expected beat.
    always @(negedge ACLK) begin
        beat_t e;
        if (ARESETn) begin
            if (m_TVALID && m_TREADY) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(m_TDATA), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(m_TDATA), 32'(e.data));
                    chk("beat_tid", 32'(m_TID), 32'(e.tid));
                    chk("beat_last", 32'(m_TLAST), 32'(e.last));
                    chk("beat_user", 32'(m_TUSER), 32'(e.user));
                end
            end
            if (m_TVALID && !m_TREADY) begin
                chk("sready_backpressure", 32'(s_TREADY), 32'd0);
            end
            chk("sready_onehot", 32'($countones(s_TREADY) <= 1), 32'd1);
        end
    end

    task automatic clear_reqs();
        for (int r = 0; r < N; r++) begin
            head[r] = 0;
            tail[r] = 0;
        end
    endtask

    task automatic add_beat(input int r, input logic [15:0] d,
                            input logic last, input logic [3:0] u);
        rq[r][tail[r]] = '{data: d, last: last, user: u, tid: 2'(r)};
        tail[r]++;
    endtask

    task automatic add_rand_msg(input int r, input int len);
        for (int k = 0; k < len; k++) begin
            add_beat(r, 16'($urandom), (k == len - 1),
                     4'($urandom_range(0, 5)));
        end
    endtask

    function automatic int pick(input int rem [N]);
`ifdef SHA_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) begin
            if (rem[i] > 0) return i;
        end
`else
        for (int i = 1; i <= N; i++) begin
            int r;
            r = (lg_model + i) % N;
            if (rem[r] > 0) return r;
        end
`endif
        return 0;
    endfunction

    // Reference: whole messages are granted in arbitration order.
    task automatic build_model();
        int    rem [N];
        int    ptr [N];
        int    total;
        int    w;
        beat_t b;
        total = 0;
        for (int r = 0; r < N; r++) begin
            rem[r] = 0;
            ptr[r] = head[r];
            for (int k = head[r]; k < tail[r]; k++) begin
                if (rq[r][k].last) rem[r]++;
            end
            total += rem[r];
        end
        while (total > 0) begin
            w = pick(rem);
            lg_model = w;
            do begin
                b = rq[w][ptr[w]];
                ptr[w]++;
                exp_q.push_back(b);
            end while (!b.last);
            rem[w]--;
            total--;
        end
    endtask

    task automatic update_drive();
        logic [N-1:0]     v;
        logic [N-1:0]     l;
        logic [DWALL-1:0] d;
        logic [UWALL-1:0] u;
        bit               first;
        v = '0;
        l = '0;
        d = '0;
        u = '0;
        for (int r = 0; r < N; r++) begin
            if (head[r] < tail[r]) begin
                first = (head[r] == 0) || rq[r][head[r] - 1].last;
                if (first || $urandom_range(0, 3) != 0) v |= N'(1) << r;
                l |= N'(rq[r][head[r]].last) << r;
                d |= DWALL'(rq[r][head[r]].data) << (r * DW);
                u |= UWALL'(rq[r][head[r]].user) << (r * 4);
            end
        end
        s_TVALID = v;
        s_TLAST  = l;
        s_TDATA  = d;
        s_TUSER  = u;
    endtask

    function automatic bit drained();
        for (int r = 0; r < N; r++) begin
            if (head[r] < tail[r]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_reset_vals();
        chk("rst_m_TVALID", 32'(m_TVALID), 32'd0);
        chk("rst_m_TDATA", 32'(m_TDATA), 32'd0);
        chk("rst_m_TLAST", 32'(m_TLAST), 32'd0);
        chk("rst_m_TUSER", 32'(m_TUSER), 32'd0);
        chk("rst_m_TID", 32'(m_TID), 32'd0);
        chk("rst_s_TREADY", 32'(s_TREADY), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
    endtask

    // One clock: sample at negedge, drive just after posedge.
    task automatic cycle(input int rmode);
        logic [N-1:0] a;
        bit           ohs;
        @(negedge ACLK);
        if (dd_check) begin
            chk("busy_after_digest", 32'(busy), 32'd0);
            chk("sready_after_digest", 32'(s_TREADY), 32'd0);
            dd_check = 0;
        end
        a   = s_TVALID & s_TREADY;
        ohs = m_TVALID && m_TREADY && m_TLAST;
        @(posedge ACLK);
        #1;
        if (digest_done) dd_check = 1;
        digest_done = 1'b0;
        if (ohs) begin
            cd = int'($urandom_range(1, 5));
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) digest_done = 1'b1;
        end
        for (int r = 0; r < N; r++) begin
            if (((a >> r) & N'(1)) != '0) head[r]++;
        end
        update_drive();
        case (rmode)
            0: m_TREADY = 1'b1;
            1: m_TREADY = ($urandom_range(0, 2) != 0);
            default: begin
                m_TREADY = (tog % 4 == 0) || (tog % 4 == 3);
                tog++;
            end
        endcase
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        clear_reqs();
        update_drive();
        digest_done = 1'b0;
        cd = 0;
        dd_check = 0;
        #1;
        check_reset_vals();
        exp_q.delete();
        lg_model = N - 1;
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
    endtask

    task automatic run_phase(input int rmode, input int abort);
        bit done;
        done = 0;
        build_model();
        tog = 0;
        m_TREADY = 1'b1;
        update_drive();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            cycle(rmode);
            if (cyc == abort) begin
                do_reset();
                return;
            end
            if (exp_q.size() == 0 && drained() && cd == 0 &&
                !digest_done && !busy) begin
                done = 1;
                break;
            end
        end
        chk("phase_complete", 32'(done), 32'd1);
        chk("grant_id_last", 32'(grant_id), 32'(lg_model));
    endtask

    initial begin
        ARESETn     = 1'b0;
        s_TVALID    = '0;
        s_TDATA     = '0;
        s_TLAST     = '0;
        s_TUSER     = '0;
        m_TREADY    = 1'b1;
        digest_done = 1'b0;
        clear_reqs();
        #1;
        check_reset_vals();
        repeat (2) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;

        // Contention: expected order 0,1,3,0.
        clear_reqs();
        add_rand_msg(0, 2);
        add_rand_msg(0, 2);
        add_rand_msg(1, 2);
        add_rand_msg(3, 2);
        run_phase(0, -1);

        // Single requester, three beats.
        clear_reqs();
        add_beat(2, 16'h1111, 1'b0, 4'h1);
        add_beat(2, 16'h2222, 1'b0, 4'h1);
        add_beat(2, 16'h3333, 1'b1, 4'h1);
        run_phase(0, -1);

        // Backpressure pattern 1,0,0,1 on a four-beat message.
        clear_reqs();
        add_rand_msg(1, 4);
        run_phase(2, -1);

        // Requester 1 waits while 0 holds the pipeline.
        clear_reqs();
        add_rand_msg(0, 2);
        add_rand_msg(1, 3);
        run_phase(1, -1);

        // Stray digest_done in IDLE is ignored.
        digest_done = 1'b1;
        cycle(0);
        cycle(0);
        chk("stray_digest_grant", 32'(grant_id), 32'(lg_model));

        // Randomized traffic.
        for (int p = 0; p < 12; p++) begin
            int mask;
            clear_reqs();
            mask = int'($urandom_range(1, 15));
            for (int r = 0; r < N; r++) begin
                if (((mask >> r) & 1) != 0) begin
                    int nm;
                    nm = int'($urandom_range(1, 2));
                    for (int m = 0; m < nm; m++) begin
                        add_rand_msg(r, int'($urandom_range(1, 4)));
                    end
                end
            end
            run_phase(int'($urandom_range(0, 2)), -1);
        end

        // Reset after the second of four beats is accepted.
        clear_reqs();
        add_rand_msg(3, 4);
        run_phase(0, 2);

        // After reset requester 0 wins first.
        clear_reqs();
        for (int r = 0; r < N; r++) add_rand_msg(r, 2);
        run_phase(1, -1);

`ifdef SHA_ARB_FIXED_PRIO_EN
        clear_reqs();
        for (int m = 0; m < 3; m++) begin
            add_rand_msg(1, 2);
            add_rand_msg(2, 2);
        end
        run_phase(0, -1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
